// File: rtl/second_game_pkg.sv
// Shared types and helpers for the second game's pixel renderer.
// Local coordinates are CW-bit signed so sprites near the window edge clip instead of wrapping.
package second_game_pkg;

  localparam int CW = 12;

  typedef logic [11:0] rgb12_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  // |a - b| with one extra bit so the subtraction can never overflow
  function automatic logic [CW:0] abs_diff(input logic signed [CW-1:0] a,
                                           input logic signed [CW-1:0] b);
    logic signed [CW:0] d;
    d = {a[CW-1], a} - {b[CW-1], b};
    if (d[CW]) d = -d;
    return d;
  endfunction

endpackage

// File: rtl/second_game_sprite_hit.sv
// One sprite box test: hit when enabled and both axis distances are within PLAYER_SIZE (inclusive).
// Purely combinational; sprite centre x is unsigned window-local, extended to signed for the compare.
import second_game_pkg::*;

module second_game_sprite_hit #(
  parameter int XW          = 9,
  parameter int PLAYER_SIZE = 20,
  parameter int PLAYER_Y    = 10
) (
  input  logic signed [CW-1:0] i_h,
  input  logic signed [CW-1:0] i_v,
  input  logic [XW-1:0]        i_x,
  input  logic                 i_en,
  output logic                 o_hit
);

  localparam logic signed [CW-1:0] LP_Y = CW'(PLAYER_Y);
  localparam logic [CW:0]          LP_S = (CW+1)'(PLAYER_SIZE);

  logic signed [CW-1:0] w_x;

  assign w_x   = $signed({{(CW-XW){1'b0}}, i_x});
  assign o_hit = i_en && (abs_diff(i_h, w_x) <= LP_S) && (abs_diff(i_v, LP_Y) <= LP_S);

endmodule

// File: rtl/second_game_renderer.sv
// Game-window renderer: sprites over obstacles, 2-cycle latency to match the synchronous obstacle RAM.
// Tracks per-player obstacle collisions per frame and runs a hit-flash FSM on frame boundaries.
import second_game_pkg::*;

module second_game_renderer #(
  parameter int             START_X       = 400,
  parameter int             SCREEN_WIDTH  = 400,
  parameter int             SCREEN_HEIGHT = 600,
  parameter int             NUM_PLAYERS   = 2,
  parameter int             PLAYER_SIZE   = 20,
  parameter int             PLAYER_Y      = 10,
  parameter int             FLASH_FRAMES  = 30,
  parameter logic [47:0]    PLAYER_COLOR  = {12'hF00, 12'hFF0, 12'hF0F, 12'h0FF},
  parameter rgb12_t         OBSTACLE_COLOR = 12'h0F0,
  parameter rgb12_t         BKG_COLOR     = 12'h00F,
  parameter rgb12_t         FLASH_COLOR   = 12'hFFF,
  localparam int            XW            = $clog2(SCREEN_WIDTH),
  localparam int            YW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_disp_enbl,
  input  logic [10:0]               i_h_coord,
  input  logic [9:0]                i_v_coord,
  output logic [XW-1:0]             o_screen_x,
  output logic [YW-1:0]             o_screen_y,
  input  logic                      i_is_obstacle,
  input  logic [NUM_PLAYERS*XW-1:0] i_player_x,
  input  logic [NUM_PLAYERS-1:0]    i_player_en,
  output logic [3:0]                o_red,
  output logic [3:0]                o_green,
  output logic [3:0]                o_blue,
  output logic [NUM_PLAYERS-1:0]    o_collision,
  output logic                      o_flash_active
);

  localparam int                   CNTW = $clog2(FLASH_FRAMES + 1);
  localparam logic signed [CW-1:0] LP_SX = CW'(START_X);
  localparam logic signed [CW-1:0] LP_W  = CW'(SCREEN_WIDTH);
  localparam logic signed [CW-1:0] LP_H  = CW'(SCREEN_HEIGHT);

  // Stage 0: window-local coordinates and sprite hits
  logic signed [CW-1:0]   w_h, w_v;
  logic                   w_inwin;
  logic [NUM_PLAYERS-1:0] w_hit;

  assign w_h        = $signed({1'b0, i_h_coord}) - LP_SX;
  assign w_v        = $signed({2'b00, i_v_coord});
  assign w_inwin    = (w_h >= 0) && (w_h < LP_W) && (w_v < LP_H);
  assign o_screen_x = w_h[XW-1:0];
  assign o_screen_y = w_v[YW-1:0];

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_hit
    second_game_sprite_hit #(
      .XW          (XW),
      .PLAYER_SIZE (PLAYER_SIZE),
      .PLAYER_Y    (PLAYER_Y)
    ) u_hit (
      .i_h   (w_h),
      .i_v   (w_v),
      .i_x   (i_player_x[g*XW +: XW]),
      .i_en  (i_player_en[g]),
      .o_hit (w_hit[g])
    );
  end

  // Stage 1 registers
  logic signed [CW-1:0]   r_v, r_v_prev;
  logic                   r_de, r_inwin;
  logic [NUM_PLAYERS-1:0] r_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v      <= '0;
      r_v_prev <= '0;
      r_de     <= 1'b0;
      r_inwin  <= 1'b0;
      r_hit    <= '0;
    end else begin
      r_v      <= w_v;
      r_v_prev <= r_v;
      r_de     <= i_disp_enbl;
      r_inwin  <= w_inwin;
      r_hit    <= w_hit;
    end
  end

  // Stage 1 combinational: visibility, collisions, frame boundary
  logic                   w_vis, w_bound;
  logic [NUM_PLAYERS-1:0] w_coll;

  assign w_vis   = r_de && r_inwin;
  assign w_coll  = r_hit & {NUM_PLAYERS{w_vis && i_is_obstacle}};
  assign w_bound = (r_v == 0) && (r_v_prev != 0);

  flash_state_t           r_state, w_state_nxt;
  logic [CNTW-1:0]        r_cnt, w_cnt_nxt;
  logic [NUM_PLAYERS-1:0] r_mask, w_mask_nxt;
  logic                   r_phase, w_phase_nxt;
  logic [NUM_PLAYERS-1:0] r_sticky;

  // Lowest-index sprite wins, so scan downward and let later matches override
  rgb12_t w_color;
  always_comb begin
    w_color = '0;
    if (w_vis) begin
      w_color = i_is_obstacle ? OBSTACLE_COLOR : BKG_COLOR;
      for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
        if (r_hit[p]) begin
          w_color = (r_state == FLASH && r_mask[p] && r_phase) ? FLASH_COLOR
                                                              : PLAYER_COLOR[(3-p)*12 +: 12];
        end
      end
    end
  end

  // Flash FSM advances only on frame boundaries; sticky holds the frame just ended
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_phase_nxt = r_phase;
    if (w_bound) begin
      case (r_state)
        IDLE: begin
          if (|r_sticky) begin
            w_state_nxt = FLASH;
            w_cnt_nxt   = CNTW'(FLASH_FRAMES);
            w_mask_nxt  = r_sticky;
            w_phase_nxt = 1'b1;
          end
        end
        FLASH: begin
          w_phase_nxt = ~r_phase;
          if (|r_sticky) begin
            w_cnt_nxt  = CNTW'(FLASH_FRAMES);
            w_mask_nxt = r_mask | r_sticky;
          end else if (r_cnt <= 1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_mask_nxt  = '0;
            w_phase_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  rgb12_t r_color;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_mask         <= '0;
      r_phase        <= 1'b0;
      r_sticky       <= '0;
      r_color        <= '0;
      o_collision    <= '0;
      o_flash_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_mask         <= w_mask_nxt;
      r_phase        <= w_phase_nxt;
      r_sticky       <= w_bound ? w_coll : (r_sticky | w_coll);
      r_color        <= w_color;
      o_collision    <= w_bound ? r_sticky : '0;
      o_flash_active <= (w_state_nxt == FLASH);
    end
  end

  assign o_red   = r_color[11:8];
  assign o_green = r_color[7:4];
  assign o_blue  = r_color[3:0];

endmodule

// File: tb/tb_second_game_renderer.sv
// Directed + randomized pixel stream checked against a per-pixel, frame-level reference model.
module tb_second_game_renderer;

  typedef struct {
    int       h;
    int       v;
    bit       de;
    bit       ob;
    int       x0;
    int       x1;
    bit [1:0] en;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de = 1'b0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic [8:0]  sx;
  logic [9:0]  sy;
  logic        obs = 1'b0;
  logic [17:0] px = '0;
  logic [1:0]  pen = '0;
  logic [3:0]  r, g, b;
  logic [1:0]  coll;
  logic        fa;

  int checks = 0;
  int errors = 0;

  second_game_renderer dut (
    .i_clk(clk), .i_rst(rst), .i_disp_enbl(de), .i_h_coord(hc), .i_v_coord(vc),
    .o_screen_x(sx), .o_screen_y(sy), .i_is_obstacle(obs), .i_player_x(px),
    .i_player_en(pen), .o_red(r), .o_green(g), .o_blue(b), .o_collision(coll),
    .o_flash_active(fa)
  );

  always #5 clk = ~clk;

  // Current sprite configuration
  int       cur_x0 = 100;
  int       cur_x1 = 300;
  bit [1:0] cur_en = 2'b01;

  // Reference model state
  bit       m_flash = 0;
  int       m_cnt = 0;
  bit [1:0] m_mask = 0;
  bit       m_phase = 0;
  bit [1:0] m_sticky = 0;
  int       m_vprev = 0;
  pix_t     pend = '{0, 0, 0, 0, 0, 0, 2'b00};
  bit [11:0] e_col = 0;
  bit [1:0]  e_coll = 0;
  bit        e_fa = 0;
  bit        e_have = 0;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic bit [11:0] pcolor(input int p);
    return (p == 0) ? 12'hF00 : 12'hFF0;
  endfunction

  task automatic model_pixel(input pix_t q);
    int       hl;
    bit       vis, bound;
    bit [1:0] hit, cl, old;
    int       xs[2];
    hl    = q.h - 400;
    vis   = q.de && hl >= 0 && hl < 400 && q.v < 600;
    xs[0] = q.x0;
    xs[1] = q.x1;
    for (int p = 0; p < 2; p++)
      hit[p] = q.en[p] && iabs(hl - xs[p]) <= 20 && iabs(q.v - 10) <= 20;
    e_col = 12'h000;
    if (vis) begin
      if (hit[0]) e_col = (m_flash && m_mask[0] && m_phase) ? 12'hFFF : pcolor(0);
      else if (hit[1]) e_col = (m_flash && m_mask[1] && m_phase) ? 12'hFFF : pcolor(1);
      else e_col = q.ob ? 12'h0F0 : 12'h00F;
    end
    cl      = (vis && q.ob) ? hit : 2'b00;
    bound   = (q.v == 0) && (m_vprev != 0);
    m_vprev = q.v;
    e_coll  = 2'b00;
    if (bound) begin
      old      = m_sticky;
      e_coll   = old;
      m_sticky = cl;
      if (!m_flash) begin
        if (old != 0) begin
          m_flash = 1; m_cnt = 30; m_mask = old; m_phase = 1;
        end
      end else begin
        m_phase = !m_phase;
        if (old != 0) begin
          m_cnt  = 30;
          m_mask = m_mask | old;
        end else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_flash = 0; m_mask = 0; m_phase = 0;
          end
        end
      end
    end else begin
      m_sticky = m_sticky | cl;
    end
    e_fa = m_flash;
  endtask

  // One pixel per clock; obstacle data for the previous pixel rides along with this one
  task automatic step(input int h, input int v, input bit d, input bit ob, input bit rs);
    pix_t nw;
    @(negedge clk);
    if (e_have) begin
      checks++;
      assert ({r, g, b} === e_col)
        else begin errors++; $error("FAIL colour got=%h exp=%h", {r, g, b}, e_col); end
      checks++;
      assert (coll === e_coll)
        else begin errors++; $error("FAIL collision got=%b exp=%b", coll, e_coll); end
      checks++;
      assert (fa === e_fa)
        else begin errors++; $error("FAIL flash_active got=%b exp=%b", fa, e_fa); end
    end
    rst = rs;
    hc  = 11'(h);
    vc  = 10'(v);
    de  = d;
    obs = pend.ob;
    px  = {9'(cur_x1), 9'(cur_x0)};
    pen = cur_en;
    if (rs) begin
      m_flash = 0; m_cnt = 0; m_mask = 0; m_phase = 0; m_sticky = 0; m_vprev = 0;
      e_col = 0; e_coll = 0; e_fa = 0;
      nw = '{0, 0, 0, 0, 0, 0, 2'b00};
    end else begin
      model_pixel(pend);
      nw = '{h, v, d, ob, cur_x0, cur_x1, cur_en};
    end
    e_have = 1;
    pend   = nw;
    #1;
    if (h - 400 >= 0 && h - 400 < 400) begin
      checks++;
      assert ({sx, sy} === {9'(h - 400), 10'(v)})
        else begin errors++; $error("FAIL screen_xy got=%0d,%0d exp=%0d,%0d", sx, sy, h - 400, v); end
    end
  endtask

  // One frame: a v=0 lead pixel (frame boundary) then a body of rows 1..40
  task automatic frame(input int nbody, input int mode);
    int  h, v, p;
    bit  ob, d;
    for (int i = 0; i <= nbody; i++) begin
      if (i <= 3 && cur_en != 0) begin
        p = cur_en[0] ? 0 : 1;
        if (cur_en == 2'b11) p = $urandom_range(0, 1);
        h = 400 + ((p == 0) ? cur_x0 : cur_x1) + $urandom_range(0, 46) - 23;
        v = $urandom_range(1, 32);
      end else begin
        h = $urandom_range(380, 820);
        v = $urandom_range(1, 40);
      end
      if (i == 0) v = 0;
      ob = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      d  = (mode == 2) ? ($urandom_range(0, 7) != 0) : 1'b1;
      step(h, v, d, ob, 1'b0);
    end
  endtask

  initial begin
    // Reset held 3 cycles while coordinates are valid
    for (int i = 0; i < 3; i++) step(520, 10, 1, 0, 1);
    // Sprite paint and inclusive box edge
    step(520, 10, 1, 0, 0);
    step(521, 10, 1, 0, 0);
    // Overlap: player 0 wins, also over an obstacle
    cur_x1 = 100; cur_en = 2'b11;
    step(520, 10, 1, 1, 0);
    // Clip outside the window, and blanking suppresses collision
    cur_x0 = 5;
    step(397, 10, 1, 1, 0);
    step(405, 10, 0, 1, 0);
    cur_x0 = 100; cur_x1 = 300;
    // Let the first flash run out
    for (int f = 0; f < 33; f++) frame(6, 0);
    // Player 1 collision, then reload with player 0 twenty frames in
    cur_en = 2'b10;
    frame(6, 1);
    cur_en = 2'b11;
    for (int f = 0; f < 19; f++) frame(6, 0);
    cur_en = 2'b01;
    frame(6, 1);
    cur_en = 2'b11;
    for (int f = 0; f < 33; f++) frame(6, 0);
    // Random sprites, obstacles and blanking, with a reset mid-frame
    for (int f = 0; f < 12; f++) begin
      cur_x0 = $urandom_range(0, 399);
      cur_x1 = $urandom_range(0, 399);
      cur_en = 2'($urandom_range(0, 3));
      frame(8, 2);
      if (f == 6) begin
        step(600, 15, 1, 0, 1);
        step(600, 15, 1, 0, 1);
      end
    end
    step(500, 5, 1, 0, 0);
    step(500, 5, 1, 0, 0);
    step(500, 5, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
